// File: rtl/rgb_fade_sequencer.sv
// rgb_fade_sequencer: steps the board RGB LED through an 8-colour palette with PWM dimming.
// AUTO mode fades each colour in, holds it, fades it out, then advances; MANUAL mode steps on button edges.
// Latency: LED pins are active-low and registered one clock after the pwm_cnt/level_o compare.
module rgb_fade_sequencer #(
  parameter int PWM_BITS   = 8,
  parameter int TICK_DIV   = 12000,
  parameter int HOLD_TICKS = 500
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                step_i,
  input  logic                mode_i,
  output logic                LED_R,
  output logic                LED_G,
  output logic                LED_B,
  output logic [2:0]          color_o,
  output logic [PWM_BITS-1:0] level_o
);

  // Prescaler needs at least one bit even when TICK_DIV is 1 (tick every cycle).
  localparam int PSC_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HOLD_W = $clog2(HOLD_TICKS) + 1;

  localparam logic [PSC_W-1:0]    PSC_LAST     = PSC_W'(TICK_DIV - 1);
  localparam logic [PSC_W-1:0]    PSC_ONE      = PSC_W'(1);
  localparam logic [HOLD_W-1:0]   HOLD_LAST    = HOLD_W'(HOLD_TICKS - 1);
  localparam logic [HOLD_W-1:0]   HOLD_ONE     = HOLD_W'(1);
  localparam logic [PWM_BITS-1:0] LVL_MAX      = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] LVL_ONE      = PWM_BITS'(1);
  localparam logic [PWM_BITS-1:0] LVL_NEAR_MAX = LVL_MAX - LVL_ONE;
  localparam logic [2:0]          COLOR_ONE    = 3'd1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FADE_IN,
    S_HOLD,
    S_FADE_OUT,
    S_MANUAL
  } state_t;

  state_t              r_state;
  logic [2:0]          r_color;
  logic [PWM_BITS-1:0] r_level;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic [PSC_W-1:0]    r_presc;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic                r_step_q;
  logic                r_led_r;
  logic                r_led_g;
  logic                r_led_b;

  logic                w_tick;
  logic                w_step_rise;
  logic                w_pwm_on;
  logic [2:0]          w_pal;

  // Palette lookup, bits ordered {R,G,B}; entry 0 is deliberately dark.
  function automatic logic [2:0] palette(input logic [2:0] idx);
    logic [2:0] rgb;
    case (idx)
      3'd0:    rgb = 3'b000;
      3'd1:    rgb = 3'b100;
      3'd2:    rgb = 3'b010;
      3'd3:    rgb = 3'b001;
      3'd4:    rgb = 3'b110;
      3'd5:    rgb = 3'b011;
      3'd6:    rgb = 3'b101;
      default: rgb = 3'b111;
    endcase
    return rgb;
  endfunction

  assign w_tick      = (r_presc == PSC_LAST);
  assign w_step_rise = step_i & ~r_step_q;
  assign w_pwm_on    = (r_pwm_cnt < r_level);
  assign w_pal       = palette(r_color);

  // Delayed copy of the step button for single-pulse edge detection.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_step_q <= 1'b0;
    end else begin
      r_step_q <= step_i;
    end
  end

  // Brightness-tick prescaler; free-running, never disturbed by mode changes.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PSC_ONE;
    end
  end

  // Free-running PWM phase counter; wraps naturally at all-ones.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pwm_cnt <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + LVL_ONE;
    end
  end

  // Sequencer FSM: mode changes outrank brightness ticks; level never leaves 0..max.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_color    <= '0;
      r_level    <= '0;
      r_hold_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (mode_i) begin
            r_state <= S_FADE_IN;
            r_level <= '0;
          end else begin
            r_state <= S_MANUAL;
            r_level <= LVL_MAX;
          end
        end

        S_FADE_IN: begin
          if (!mode_i) begin
            r_state <= S_MANUAL;
            r_level <= LVL_MAX;
          end else if (w_tick) begin
            r_level <= r_level + LVL_ONE;
            // The tick that reaches full brightness also starts the hold.
            if (r_level == LVL_NEAR_MAX) begin
              r_state    <= S_HOLD;
              r_hold_cnt <= '0;
            end
          end
        end

        S_HOLD: begin
          if (!mode_i) begin
            r_state <= S_MANUAL;
            r_level <= LVL_MAX;
          end else if (w_tick) begin
            if (r_hold_cnt == HOLD_LAST) begin
              r_state <= S_FADE_OUT;
            end else begin
              r_hold_cnt <= r_hold_cnt + HOLD_ONE;
            end
          end
        end

        S_FADE_OUT: begin
          if (!mode_i) begin
            r_state <= S_MANUAL;
            r_level <= LVL_MAX;
          end else if (w_tick) begin
            r_level <= r_level - LVL_ONE;
            // The tick that reaches darkness also advances the colour.
            if (r_level == LVL_ONE) begin
              r_state <= S_FADE_IN;
              r_color <= r_color + COLOR_ONE;
            end
          end
        end

        S_MANUAL: begin
          if (mode_i) begin
            // Leaving MANUAL swallows any coincident step request.
            r_state <= S_FADE_IN;
            r_level <= '0;
          end else begin
            r_level <= LVL_MAX;
            if (w_step_rise) begin
              r_color <= r_color + COLOR_ONE;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_level <= '0;
        end
      endcase
    end
  end

  // Registered active-low LED drive from palette bit and PWM compare.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_led_r <= 1'b1;
      r_led_g <= 1'b1;
      r_led_b <= 1'b1;
    end else begin
      r_led_r <= ~(w_pal[2] & w_pwm_on);
      r_led_g <= ~(w_pal[1] & w_pwm_on);
      r_led_b <= ~(w_pal[0] & w_pwm_on);
    end
  end

  assign LED_R   = r_led_r;
  assign LED_G   = r_led_g;
  assign LED_B   = r_led_b;
  assign color_o = r_color;
  assign level_o = r_level;

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// tb_rgb_fade_sequencer: directed checks of the RGB fade sequencer with small parameters.
// Main instance: PWM_BITS=4, TICK_DIV=2, HOLD_TICKS=3; second instance slows ticks for a duty check.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_rgb_fade_sequencer;

  logic       CLK;
  logic       RST;
  logic       step_i;
  logic       mode_i;
  logic       LED_R, LED_G, LED_B;
  logic [2:0] color_o;
  logic [3:0] level_o;

  logic       rst2;
  logic       step2;
  logic       mode2;
  logic       led_r2, led_g2, led_b2;
  logic [2:0] col2;
  logic [3:0] lvl2;

  int n;
  int n_vec;
  int n_err;

  typedef struct {
    int         n;
    logic [2:0] col;
    logic [3:0] lvl;
    logic       chk_led;
    logic [2:0] led;
  } vec_t;

  vec_t tbl [21];

  rgb_fade_sequencer #(.PWM_BITS(4), .TICK_DIV(2), .HOLD_TICKS(3)) u_dut (
    .CLK     (CLK),
    .RST     (RST),
    .step_i  (step_i),
    .mode_i  (mode_i),
    .LED_R   (LED_R),
    .LED_G   (LED_G),
    .LED_B   (LED_B),
    .color_o (color_o),
    .level_o (level_o)
  );

  rgb_fade_sequencer #(.PWM_BITS(4), .TICK_DIV(40), .HOLD_TICKS(3)) u_dut2 (
    .CLK     (CLK),
    .RST     (rst2),
    .step_i  (step2),
    .mode_i  (mode2),
    .LED_R   (led_r2),
    .LED_G   (led_g2),
    .LED_B   (led_b2),
    .color_o (col2),
    .level_o (lvl2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic adv(input int k);
    repeat (k) begin
      @(posedge CLK);
      #1;
      n++;
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  initial begin
    int lr, lg, lb, guard;

    RST    = 1'b1;
    rst2   = 1'b1;
    mode_i = 1'b1;
    step_i = 1'b0;
    mode2  = 1'b0;
    step2  = 1'b0;
    n      = 0;
    n_vec  = 0;
    n_err  = 0;

    // AUTO run from reset: {edge count after release, colour, level, check LEDs, LEDs {R,G,B}}.
    tbl[0]  = '{1,   3'd0, 4'd0,  1'b1, 3'b111};
    tbl[1]  = '{2,   3'd0, 4'd1,  1'b0, 3'b000};
    tbl[2]  = '{3,   3'd0, 4'd1,  1'b0, 3'b000};
    tbl[3]  = '{30,  3'd0, 4'd15, 1'b0, 3'b000};
    tbl[4]  = '{33,  3'd0, 4'd15, 1'b1, 3'b111};
    tbl[5]  = '{37,  3'd0, 4'd15, 1'b0, 3'b000};
    tbl[6]  = '{38,  3'd0, 4'd14, 1'b0, 3'b000};
    tbl[7]  = '{65,  3'd0, 4'd1,  1'b0, 3'b000};
    tbl[8]  = '{66,  3'd1, 4'd0,  1'b0, 3'b000};
    tbl[9]  = '{68,  3'd1, 4'd1,  1'b0, 3'b000};
    tbl[10] = '{99,  3'd1, 4'd15, 1'b1, 3'b011};
    tbl[11] = '{165, 3'd2, 4'd15, 1'b1, 3'b101};
    tbl[12] = '{231, 3'd3, 4'd15, 1'b1, 3'b110};
    tbl[13] = '{297, 3'd4, 4'd15, 1'b1, 3'b001};
    tbl[14] = '{363, 3'd5, 4'd15, 1'b1, 3'b100};
    tbl[15] = '{429, 3'd6, 4'd15, 1'b1, 3'b010};
    tbl[16] = '{461, 3'd6, 4'd1,  1'b0, 3'b000};
    tbl[17] = '{462, 3'd7, 4'd0,  1'b0, 3'b000};
    tbl[18] = '{495, 3'd7, 4'd15, 1'b1, 3'b000};
    tbl[19] = '{528, 3'd0, 4'd0,  1'b0, 3'b000};
    tbl[20] = '{530, 3'd0, 4'd1,  1'b0, 3'b000};

    repeat (3) @(posedge CLK);
    #1;
    chk("reset_leds",  int'({LED_R, LED_G, LED_B}), 7);
    chk("reset_color", int'(color_o), 0);
    chk("reset_level", int'(level_o), 0);

    RST = 1'b0;
    n   = 0;
    for (int i = 0; i < 21; i++) begin
      while (n < tbl[i].n) adv(1);
      chk($sformatf("vec%0d_color", i), int'(color_o), int'(tbl[i].col));
      chk($sformatf("vec%0d_level", i), int'(level_o), int'(tbl[i].lvl));
      if (tbl[i].chk_led)
        chk($sformatf("vec%0d_leds", i), int'({LED_R, LED_G, LED_B}), int'(tbl[i].led));
    end

    // Colour 1 fading out at level 5; drop to MANUAL.
    while (n < 650) adv(1);
    chk("fadeout_color", int'(color_o), 1);
    chk("fadeout_level", int'(level_o), 5);
    mode_i = 1'b0;
    adv(1);
    chk("to_manual_color", int'(color_o), 1);
    chk("to_manual_level", int'(level_o), 15);

    // Mode back to AUTO together with a step edge: mode change wins.
    mode_i = 1'b1;
    step_i = 1'b1;
    adv(1);
    chk("mode_vs_step_color", int'(color_o), 1);
    chk("mode_vs_step_level", int'(level_o), 0);
    step_i = 1'b0;
    adv(1);
    chk("fadein_no_tick_level", int'(level_o), 0);
    adv(1);
    chk("fadein_tick_level", int'(level_o), 1);
    step_i = 1'b1;
    adv(1);
    chk("auto_ignores_step", int'(color_o), 1);
    step_i = 1'b0;

    // MANUAL stepping up to colour 3, then PWM duty at full brightness.
    mode_i = 1'b0;
    adv(1);
    chk("manual_level", int'(level_o), 15);
    step_i = 1'b1;
    adv(1);
    chk("manual_step1", int'(color_o), 2);
    step_i = 1'b0;
    adv(1);
    step_i = 1'b1;
    adv(1);
    chk("manual_step2", int'(color_o), 3);
    step_i = 1'b0;
    lr = 0; lg = 0; lb = 0;
    for (int k = 0; k < 16; k++) begin
      adv(1);
      lr += int'(!LED_R);
      lg += int'(!LED_G);
      lb += int'(!LED_B);
    end
    chk("c3_red_low_cnt",   lr, 0);
    chk("c3_green_low_cnt", lg, 0);
    chk("c3_blue_low_cnt",  lb, 15);

    // Step held high for 10 clocks advances exactly once.
    step_i = 1'b1;
    adv(1);
    chk("held_step_first", int'(color_o), 4);
    adv(9);
    step_i = 1'b0;
    adv(1);
    chk("held_step_once", int'(color_o), 4);

    // Back to AUTO; prescaler keeps its phase, so ticks stay on even edges.
    mode_i = 1'b1;
    while (n < 696) adv(1);
    chk("refade_color", int'(color_o), 4);
    chk("refade_level", int'(level_o), 5);

    // Asynchronous reset mid-fade, observed before any clock edge.
    RST = 1'b1;
    #1;
    chk("async_rst_leds",  int'({LED_R, LED_G, LED_B}), 7);
    chk("async_rst_color", int'(color_o), 0);
    chk("async_rst_level", int'(level_o), 0);
    adv(2);
    RST = 1'b0;
    n   = 0;
    adv(1);
    chk("restart_color", int'(color_o), 0);
    chk("restart_level0", int'(level_o), 0);
    adv(1);
    chk("restart_level1", int'(level_o), 1);

    // Duty check at level 8 on the slow-tick instance, colour 5 (G and B enabled).
    rst2 = 1'b0;
    adv(1);
    for (int k = 0; k < 5; k++) begin
      step2 = 1'b1;
      adv(1);
      step2 = 1'b0;
      adv(1);
    end
    chk("dut2_color", int'(col2), 5);
    chk("dut2_manual_level", int'(lvl2), 15);
    mode2 = 1'b1;
    adv(1);
    chk("dut2_fadein_level", int'(lvl2), 0);
    guard = 0;
    while (lvl2 != 4'd8 && guard < 1000) begin
      adv(1);
      guard++;
    end
    chk("dut2_level8_reached", int'(lvl2), 8);
    lr = 0; lg = 0; lb = 0;
    for (int k = 0; k < 16; k++) begin
      adv(1);
      lr += int'(!led_r2);
      lg += int'(!led_g2);
      lb += int'(!led_b2);
    end
    chk("l8_red_low_cnt",   lr, 0);
    chk("l8_green_low_cnt", lg, 8);
    chk("l8_blue_low_cnt",  lb, 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
